// File: rtl/median3x3_seq_pkg.sv
// ----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the 3x3 median sequencer and its sorter.
//   op_t      : 4-bit sort-operation tag carried through the sorter.
//   OP_*      : tag values for the seven sort operations of one window.
//   state_t   : sequencer FSM states.
//   pix_idx() : flat pixel index k = 3*row + col within a window.
// ----------------------------------------------------------------------------
package median_pkg;

    typedef logic [3:0] op_t;

    // Rows first, then the three column passes, then the final pass.
    localparam op_t OP_ROW0    = 4'd0;
    localparam op_t OP_ROW1    = 4'd1;
    localparam op_t OP_ROW2    = 4'd2;
    localparam op_t OP_COL_MAX = 4'd3;  // min of the row maxima
    localparam op_t OP_COL_MID = 4'd4;  // mid of the row mids
    localparam op_t OP_COL_MIN = 4'd5;  // max of the row minima
    localparam op_t OP_FIN     = 4'd6;  // mid of the three above = median

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_WR,
        ST_COL,
        ST_WC,
        ST_FIN,
        ST_WF,
        ST_OUT
    } state_t;

    // 4-bit result is wide enough to index the nine window pixels.
    function automatic logic [3:0] pix_idx(input logic [1:0] row, input logic [1:0] col);
        return 4'(row) * 4'd3 + 4'(col);
    endfunction

endpackage

// File: rtl/median3x3_seq_if.sv
// ----------------------------------------------------------------------------
// median3x3_seq_if
// Window-in / median-out handshake bundle of the median sequencer.
//   win_valid/win_ready/win_data : 3x3 window, p[k] = win_data[DW*k +: DW]
//   med_valid/med_ready/med_data : median result
// Modports: slave = sequencer side, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface median3x3_seq_if #(
    parameter int DW = 8
);
    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] win_data;
    logic            med_valid;
    logic            med_ready;
    logic [DW-1:0]   med_data;

    modport slave (
        input  win_valid, win_data, med_ready,
        output win_ready, med_valid, med_data
    );

    modport master (
        output win_valid, win_data, med_ready,
        input  win_ready, med_valid, med_data
    );
endinterface

// File: rtl/median3x3_seq_sort.sv
// ----------------------------------------------------------------------------
// sort
// One-cycle registered 3-input unsigned sorter with per-input tags.
//   clk, reset          : clock, synchronous active-high reset
//   valid_i             : issue strobe
//   data0..data2        : operands; data0_id..data2_id their tags
//   valid_o             : result strobe, one cycle after valid_i
//   max_o/mid_o/min_o   : sorted values; max_id/mid_id/min_id their tags
// ----------------------------------------------------------------------------
module sort #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [3:0]    data0_id,
    input  logic [3:0]    data1_id,
    input  logic [3:0]    data2_id,
    output logic          valid_o,
    output logic [DW-1:0] max_o,
    output logic [DW-1:0] mid_o,
    output logic [DW-1:0] min_o,
    output logic [3:0]    max_id,
    output logic [3:0]    mid_id,
    output logic [3:0]    min_id
);
    typedef struct packed {
        logic [DW-1:0] v;
        logic [3:0]    id;
    } ent_t;

    ent_t a, b, c;
    ent_t x_hi, x_lo, y_hi, y_lo, z_hi, z_lo;

    assign a = {data0, data0_id};
    assign b = {data1, data1_id};
    assign c = {data2, data2_id};

    // Three compare-exchange stages: (a,b), (low,c), (high,low-high).
    assign x_hi = (a.v >= b.v) ? a : b;
    assign x_lo = (a.v >= b.v) ? b : a;
    assign y_hi = (x_lo.v >= c.v) ? x_lo : c;
    assign y_lo = (x_lo.v >= c.v) ? c : x_lo;
    assign z_hi = (x_hi.v >= y_hi.v) ? x_hi : y_hi;
    assign z_lo = (x_hi.v >= y_hi.v) ? y_hi : x_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0;
            max_o   <= '0;
            mid_o   <= '0;
            min_o   <= '0;
            max_id  <= '0;
            mid_id  <= '0;
            min_id  <= '0;
        end else begin
            valid_o <= valid_i;
            max_o   <= z_hi.v;
            mid_o   <= z_lo.v;
            min_o   <= y_lo.v;
            max_id  <= z_hi.id;
            mid_id  <= z_lo.id;
            min_id  <= y_lo.id;
        end
    end
endmodule

// File: rtl/median3x3_seq.sv
// ----------------------------------------------------------------------------
// median3x3_seq
// Computes the exact median of a 3x3 window using seven passes through one
// external 1-cycle 3-input sorter: sort each row, take min-of-max /
// mid-of-mid / max-of-min across rows, then the mid of those three.
//   clk, reset       : clock, synchronous active-high reset
//   io (slave)       : window input and median output handshakes
//   srt_valid_o      : issue strobe to sorter
//   srt_d0..srt_d2   : sorter operands
//   srt_id           : op tag, driven on all three sorter tag inputs
//   srt_valid_i      : sorter result strobe
//   srt_max/mid/min  : sorter results
//   srt_mid_id       : tag of the mid result, used to route the capture
//   err              : sticky unexpected-result flag
// ----------------------------------------------------------------------------
module median3x3_seq
    import median_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    median3x3_seq_if.slave       io,
    output logic                 srt_valid_o,
    output logic [DW-1:0]        srt_d0,
    output logic [DW-1:0]        srt_d1,
    output logic [DW-1:0]        srt_d2,
    output op_t                  srt_id,
    input  logic                 srt_valid_i,
    input  logic [DW-1:0]        srt_max,
    input  logic [DW-1:0]        srt_mid,
    input  logic [DW-1:0]        srt_min,
    input  op_t                  srt_mid_id,
    output logic                 err
);
    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;

    logic [DW-1:0] pix_q     [9];
    logic [DW-1:0] row_max_q [3];
    logic [DW-1:0] row_mid_q [3];
    logic [DW-1:0] row_min_q [3];
    logic [DW-1:0] col_q     [3];   // results of ops 3, 4, 5
    logic [DW-1:0] med_q;

    // One bit per op tag; bit 7 is never set so any tag >= 7 reads as idle.
    logic [7:0]    inflight_q;
    logic [7:0]    issue_mask, cap_mask;
    logic          cap_ok;
    logic          err_q;

    assign io.win_ready = (state_q == ST_IDLE);
    assign io.med_valid = (state_q == ST_OUT);
    assign io.med_data  = med_q;
    assign err          = err_q;

    // ------------------------------------------------------------------
    // Next state and sorter issue decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        srt_valid_o = 1'b0;
        srt_id      = OP_ROW0;
        srt_d0      = '0;
        srt_d1      = '0;
        srt_d2      = '0;

        case (state_q)
            ST_IDLE: begin
                if (io.win_valid) begin
                    state_d = ST_ROW;
                    cnt_d   = 2'd0;
                end
            end

            ST_ROW: begin
                srt_valid_o = 1'b1;
                srt_id      = op_t'(cnt_q);
                srt_d0      = pix_q[pix_idx(cnt_q, 2'd0)];
                srt_d1      = pix_q[pix_idx(cnt_q, 2'd1)];
                srt_d2      = pix_q[pix_idx(cnt_q, 2'd2)];
                if (cnt_q == 2'd2) begin
                    state_d = ST_WR;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            // Last row result lands here before the column passes read it.
            ST_WR: state_d = ST_COL;

            ST_COL: begin
                srt_valid_o = 1'b1;
                srt_id      = OP_COL_MAX + op_t'(cnt_q);
                case (cnt_q)
                    2'd0: begin
                        srt_d0 = row_max_q[0];
                        srt_d1 = row_max_q[1];
                        srt_d2 = row_max_q[2];
                    end
                    2'd1: begin
                        srt_d0 = row_mid_q[0];
                        srt_d1 = row_mid_q[1];
                        srt_d2 = row_mid_q[2];
                    end
                    default: begin
                        srt_d0 = row_min_q[0];
                        srt_d1 = row_min_q[1];
                        srt_d2 = row_min_q[2];
                    end
                endcase
                if (cnt_q == 2'd2) begin
                    state_d = ST_WC;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            ST_WC: state_d = ST_FIN;

            ST_FIN: begin
                srt_valid_o = 1'b1;
                srt_id      = OP_FIN;
                srt_d0      = col_q[0];
                srt_d1      = col_q[1];
                srt_d2      = col_q[2];
                state_d     = ST_WF;
            end

            // The final result is captured by the routing logic this cycle.
            ST_WF: state_d = ST_OUT;

            ST_OUT: begin
                if (io.med_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result routing: a result is accepted only if its tag is in flight.
    // ------------------------------------------------------------------
    always_comb begin
        issue_mask = srt_valid_o ? (8'd1 << srt_id) : 8'd0;
        cap_ok     = srt_valid_i && (srt_mid_id <= OP_FIN) && inflight_q[srt_mid_id[2:0]];
        cap_mask   = cap_ok ? (8'd1 << srt_mid_id[2:0]) : 8'd0;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            inflight_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= (inflight_q & ~cap_mask) | issue_mask;
            if (srt_valid_i && !cap_ok) err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Window and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: these data registers are reset as well, since their reset
        // value is visible on med_data and on the sorter operand outputs.
        if (reset) begin
            for (int k = 0; k < 9; k++) pix_q[k] <= '0;
            for (int r = 0; r < 3; r++) begin
                row_max_q[r] <= '0;
                row_mid_q[r] <= '0;
                row_min_q[r] <= '0;
                col_q[r]     <= '0;
            end
            med_q <= '0;
        end else begin
            if (state_q == ST_IDLE && io.win_valid) begin
                for (int k = 0; k < 9; k++) pix_q[k] <= io.win_data[DW*k +: DW];
            end

            if (cap_ok) begin
                case (srt_mid_id)
                    OP_ROW0, OP_ROW1, OP_ROW2: begin
                        row_max_q[srt_mid_id[1:0]] <= srt_max;
                        row_mid_q[srt_mid_id[1:0]] <= srt_mid;
                        row_min_q[srt_mid_id[1:0]] <= srt_min;
                    end
                    OP_COL_MAX: col_q[0] <= srt_min;
                    OP_COL_MID: col_q[1] <= srt_mid;
                    OP_COL_MIN: col_q[2] <= srt_max;
                    OP_FIN:     med_q    <= srt_mid;
                    default: ;
                endcase
            end
        end
    end
endmodule
